// File: rtl/block_loader.sv
// rtl/block_loader.sv - pixel stream loader for the current-block and search-window memories
// Byte stream in after a start; one registered memory write per accepted beat.
module block_loader #(
    parameter int CURR_DEPTH   = 256,
    parameter int SEARCH_DEPTH = 1024,
    parameter int DATA_W       = 8,
    localparam int CA          = $clog2(CURR_DEPTH),
    localparam int SA          = $clog2(SEARCH_DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              load_curr_i,
    input  logic              pix_valid_i,
    input  logic [DATA_W-1:0] pix_data_i,
    output logic              pix_ready_o,
    output logic              curr_mem_we_o,
    output logic [CA-1:0]     curr_mem_waddr_o,
    output logic [DATA_W-1:0] curr_mem_wdata_o,
    output logic              search_mem_we_o,
    output logic [SA-1:0]     search_mem_waddr_o,
    output logic [DATA_W-1:0] search_mem_wdata_o,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD_CURR,
        S_LOAD_SEARCH,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CA-1:0]      r_curr_cnt;
    logic [SA-1:0]      r_search_cnt;
    logic               r_curr_we;
    logic [CA-1:0]      r_curr_waddr;
    logic [DATA_W-1:0]  r_curr_wdata;
    logic               r_search_we;
    logic [SA-1:0]      r_search_waddr;
    logic [DATA_W-1:0]  r_search_wdata;

    logic w_ready;
    logic w_accept;
    logic w_start;
    logic w_curr_beat;
    logic w_search_beat;
    logic w_curr_last;
    logic w_search_last;

    assign w_ready       = (r_state == S_LOAD_CURR) || (r_state == S_LOAD_SEARCH);
    assign w_accept      = w_ready && pix_valid_i;
    assign w_start       = (r_state == S_IDLE) && start_i;
    assign w_curr_beat   = w_accept && (r_state == S_LOAD_CURR);
    assign w_search_beat = w_accept && (r_state == S_LOAD_SEARCH);
    assign w_curr_last   = w_curr_beat && (r_curr_cnt == CA'(CURR_DEPTH - 1));
    assign w_search_last = w_search_beat && (r_search_cnt == SA'(SEARCH_DEPTH - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_next = load_curr_i ? S_LOAD_CURR : S_LOAD_SEARCH;
                end
            end
            S_LOAD_CURR: begin
                if (w_curr_last) begin
                    w_next = S_LOAD_SEARCH;
                end
            end
            S_LOAD_SEARCH: begin
                if (w_search_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Counters stop on their last beat instead of wrapping; the next start clears them.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_curr_cnt   <= '0;
            r_search_cnt <= '0;
        end else if (w_start) begin
            r_curr_cnt   <= '0;
            r_search_cnt <= '0;
        end else begin
            if (w_curr_beat && !w_curr_last) begin
                r_curr_cnt <= r_curr_cnt + 1'b1;
            end
            if (w_search_beat && !w_search_last) begin
                r_search_cnt <= r_search_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_curr_we      <= 1'b0;
            r_curr_waddr   <= '0;
            r_curr_wdata   <= '0;
            r_search_we    <= 1'b0;
            r_search_waddr <= '0;
            r_search_wdata <= '0;
        end else begin
            r_curr_we   <= w_curr_beat;
            r_search_we <= w_search_beat;
            if (w_curr_beat) begin
                r_curr_waddr <= r_curr_cnt;
                r_curr_wdata <= pix_data_i;
            end
            if (w_search_beat) begin
                r_search_waddr <= r_search_cnt;
                r_search_wdata <= pix_data_i;
            end
        end
    end

    // DONE lines up with the final search write because both are one cycle after the last beat.
    assign pix_ready_o        = w_ready;
    assign busy_o             = (r_state != S_IDLE);
    assign done_o             = (r_state == S_DONE);
    assign curr_mem_we_o      = r_curr_we;
    assign curr_mem_waddr_o   = r_curr_waddr;
    assign curr_mem_wdata_o   = r_curr_wdata;
    assign search_mem_we_o    = r_search_we;
    assign search_mem_waddr_o = r_search_waddr;
    assign search_mem_wdata_o = r_search_wdata;

endmodule

// File: tb/tb_block_loader.sv
// tb/tb_block_loader.sv - self-checking bench for block_loader
module tb_block_loader;

    localparam int CD = 256;
    localparam int SD = 1024;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       start_i = 1'b0;
    logic       load_curr_i = 1'b0;
    logic       pix_valid_i = 1'b0;
    logic [7:0] pix_data_i = 8'd0;
    logic       pix_ready_o;
    logic       curr_mem_we_o;
    logic [7:0] curr_mem_waddr_o;
    logic [7:0] curr_mem_wdata_o;
    logic       search_mem_we_o;
    logic [9:0] search_mem_waddr_o;
    logic [7:0] search_mem_wdata_o;
    logic       busy_o;
    logic       done_o;

    block_loader #(.CURR_DEPTH(CD), .SEARCH_DEPTH(SD), .DATA_W(8)) dut (
        .clk_i              (clk),
        .rst_i              (rst_i),
        .start_i            (start_i),
        .load_curr_i        (load_curr_i),
        .pix_valid_i        (pix_valid_i),
        .pix_data_i         (pix_data_i),
        .pix_ready_o        (pix_ready_o),
        .curr_mem_we_o      (curr_mem_we_o),
        .curr_mem_waddr_o   (curr_mem_waddr_o),
        .curr_mem_wdata_o   (curr_mem_wdata_o),
        .search_mem_we_o    (search_mem_we_o),
        .search_mem_waddr_o (search_mem_waddr_o),
        .search_mem_wdata_o (search_mem_wdata_o),
        .busy_o             (busy_o),
        .done_o             (done_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 loading, 2 done; k counts accepted beats of the load.
    int         m_phase = 0;
    int         m_k = 0;
    int         m_total = 0;
    bit         m_lc = 1'b0;
    logic       m_cwe = 1'b0;
    logic       m_swe = 1'b0;
    logic       m_done = 1'b0;
    logic [7:0] m_caddr = 8'd0;
    logic [7:0] m_cdata = 8'd0;
    logic [9:0] m_saddr = 10'd0;
    logic [7:0] m_sdata = 8'd0;

    always @(posedge clk) begin
        if (rst_i) begin
            m_phase = 0; m_k = 0; m_total = 0; m_lc = 1'b0;
            m_cwe = 1'b0; m_swe = 1'b0; m_done = 1'b0;
            m_caddr = 8'd0; m_cdata = 8'd0; m_saddr = 10'd0; m_sdata = 8'd0;
        end else begin
            m_cwe = 1'b0; m_swe = 1'b0; m_done = 1'b0;
            if (m_phase == 0) begin
                if (start_i) begin
                    m_phase = 1; m_k = 0; m_lc = load_curr_i;
                    m_total = load_curr_i ? CD + SD : SD;
                end
            end else if (m_phase == 1) begin
                if (pix_valid_i) begin
                    if (m_lc && m_k < CD) begin
                        m_cwe = 1'b1; m_caddr = 8'(m_k); m_cdata = pix_data_i;
                    end else begin
                        m_swe = 1'b1; m_saddr = 10'(m_lc ? m_k - CD : m_k); m_sdata = pix_data_i;
                    end
                    m_k++;
                    if (m_k == m_total) begin
                        m_phase = 2; m_done = 1'b1;
                    end
                end
            end else begin
                m_phase = 0;
            end
        end
    end

    int         cyc = 0;
    int         n_cw, n_sw, n_done, n_busy, n_both, cyc_c255, cyc_s0;
    logic [31:0] first_caddr, d_we, d_addr, d_data;

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("ready", pix_ready_o, m_phase == 1);
            chk("busy", busy_o, m_phase != 0);
            chk("done", done_o, m_done);
            chk("curr_we", curr_mem_we_o, m_cwe);
            chk("curr_waddr", curr_mem_waddr_o, m_caddr);
            chk("curr_wdata", curr_mem_wdata_o, m_cdata);
            chk("search_we", search_mem_we_o, m_swe);
            chk("search_waddr", search_mem_waddr_o, m_saddr);
            chk("search_wdata", search_mem_wdata_o, m_sdata);
            if (curr_mem_we_o === 1'b1) begin
                if (n_cw == 0) first_caddr = curr_mem_waddr_o;
                n_cw++;
                if (curr_mem_waddr_o == 8'd255) cyc_c255 = cyc;
            end
            if (search_mem_we_o === 1'b1) begin
                n_sw++;
                if (search_mem_waddr_o == 10'd0) cyc_s0 = cyc;
            end
            if (curr_mem_we_o === 1'b1 && search_mem_we_o === 1'b1) n_both++;
            if (done_o === 1'b1) begin
                n_done++;
                d_we = search_mem_we_o; d_addr = search_mem_waddr_o; d_data = search_mem_wdata_o;
            end
            if (busy_o === 1'b1) n_busy++;
        end
        cyc++;
    end

    task automatic clear_sb();
        n_cw = 0; n_sw = 0; n_done = 0; n_busy = 0; n_both = 0;
        cyc_c255 = -100; cyc_s0 = 0; first_caddr = 32'hffff; d_we = 0; d_addr = 0; d_data = 0;
    endtask

    // Streams one load; returns in cycle t+2 after the last beat, with the DUT idle.
    task automatic run_load(input bit lc, input bit stall, input bit ign_mid, input bit start_in_done);
        int  total, idx, ph, budget;
        bit  v, acc;
        total = lc ? CD + SD : SD;
        clear_sb();
        start_i = 1'b1; load_curr_i = lc; pix_valid_i = 1'b0;
        @(posedge clk); #1;
        start_i = 1'b0;
        idx = 0; ph = 0; budget = 0;
        while (idx < total && budget < 4 * total) begin
            v = stall ? ((ph % 6) == 0 || (ph % 6) == 3 || (ph % 6) == 4) : 1'b1;
            ph++;
            pix_valid_i = v;
            pix_data_i  = 8'(idx);
            start_i     = ign_mid && idx == 600;
            load_curr_i = 1'b1;
            acc = v && (pix_ready_o === 1'b1);
            @(posedge clk); #1;
            if (acc) idx++;
            budget++;
        end
        chk("load_beats", idx, total);
        pix_valid_i = 1'b0;
        start_i     = start_in_done;
        @(posedge clk); #1;
        start_i = 1'b0;
        chk("curr_writes", n_cw, lc ? 256 : 0);
        chk("search_writes", n_sw, 1024);
        chk("done_pulses", n_done, 1);
        chk("both_we", n_both, 0);
        chk("done_with_write", d_we, 1);
        chk("done_addr", d_addr, 1023);
        chk("done_data", d_data, 255);
        if (lc) chk("first_curr_addr", first_caddr, 0);
        if (!stall) chk("busy_cycles", n_busy, lc ? 1281 : 1025);
        if (lc && !stall) chk("handover_gap", cyc_s0 - cyc_c255, 1);
    endtask

    task automatic run_reset_abort();
        int idx;
        clear_sb();
        start_i = 1'b1; load_curr_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (idx = 0; idx < 100; idx++) begin
            pix_valid_i = 1'b1; pix_data_i = 8'(idx);
            @(posedge clk); #1;
        end
        pix_valid_i = 1'b1; pix_data_i = 8'd100; rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0; pix_valid_i = 1'b0;
        chk("rst_curr_we", curr_mem_we_o, 0);
        chk("rst_curr_waddr", curr_mem_waddr_o, 0);
        chk("rst_ready", pix_ready_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_pre_writes", n_cw, 100);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        cmp_en = 1'b1;
        rst_i  = 1'b0;
        chk("reset_ready", pix_ready_o, 0);
        chk("reset_busy", busy_o, 0);
        chk("reset_done", done_o, 0);
        chk("reset_search_waddr", search_mem_waddr_o, 0);
        @(posedge clk); #1;
        run_load(1'b1, 1'b0, 1'b0, 1'b0);
        run_load(1'b0, 1'b0, 1'b0, 1'b0);
        run_load(1'b1, 1'b1, 1'b0, 1'b0);
        run_load(1'b0, 1'b1, 1'b1, 1'b1);
        run_load(1'b1, 1'b0, 1'b0, 1'b0);
        run_reset_abort();
        run_load(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
